// File: rtl/config_loader.sv
// config_loader: serial-to-parallel front end for the configuration register bank.
// Receives 13-bit frames {addr[3:0], data[7:0], parity} MSB first on sdi while
// sen is high, checks even parity, address range and frame length, then drives
// the shared din bus and a one-hot load strobe into the addressed cell.
//
// Handshake: sen is a frame enable, high for exactly the 13 bit cycles of a
// frame; sdi is sampled on every rising edge where sen=1. The outputs din/load
// are registered. load is high for a single cycle and is the only qualifier for
// din, which holds its last accepted value otherwise. frame_err is a one-cycle
// pulse per rejected frame.
module config_loader #(
  parameter int NCELLS = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sen,
  input  logic              sdi,
  output logic [7:0]        din,
  output logic [NCELLS-1:0] load,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        err_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    EVAL     = 2'd2,
    WAIT_LOW = 2'd3
  } state_e;

  // Address field is fixed at 4 bits, so compare in 5 bits to allow NCELLS=16.
  localparam logic [4:0] NCELLS_W = 5'(NCELLS);
  localparam logic [3:0] LAST_BIT = 4'd12;

  state_e              state_q, state_d;
  logic [12:0]         sr_q, sr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          din_q, din_d;
  logic [NCELLS-1:0]   load_q, load_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [3:0]          frame_addr;
  logic [7:0]          frame_data;
  logic                parity_ok;
  logic                addr_ok;
  logic                reject;

  assign frame_addr = sr_q[12:9];
  assign frame_data = sr_q[8:1];
  assign parity_ok  = ~(^sr_q);
  assign addr_ok    = ({1'b0, frame_addr} < NCELLS_W);

  // State, shift register and output registers; reset lands in WAIT_LOW so a
  // frame already in flight at reset release is never picked up halfway.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= WAIT_LOW;
      sr_q      <= '0;
      cnt_q     <= '0;
      din_q     <= '0;
      load_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      load_q    <= load_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state, bit capture and accept/reject decision.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    din_d     = din_q;
    load_d    = '0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    reject    = 1'b0;

    case (state_q)
      WAIT_LOW: begin
        if (!sen) state_d = IDLE;
      end
      IDLE: begin
        if (sen) begin
          // This edge captures bit 0 of the new frame.
          sr_d    = {12'd0, sdi};
          cnt_d   = 4'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sen) begin
          sr_d = {sr_q[11:0], sdi};
          if (cnt_q == LAST_BIT) begin
            state_d = EVAL;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          // sen dropped before all 13 bits arrived: short frame.
          reject  = 1'b1;
          state_d = IDLE;
        end
      end
      EVAL: begin
        if (parity_ok && addr_ok && !sen) begin
          din_d = frame_data;
          for (int i = 0; i < NCELLS; i++) begin
            load_d[i] = (frame_addr == 4'(i));
          end
          state_d = IDLE;
        end else begin
          // sen still high here is an overrun; wait for it to fall.
          reject  = 1'b1;
          state_d = sen ? WAIT_LOW : IDLE;
        end
      end
      default: state_d = WAIT_LOW;
    endcase

    // A reject with several causes still counts once.
    if (reject) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign din       = din_q;
  assign load      = load_q;
  assign frame_err = err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_config_loader.sv
// Testbench for config_loader: randomized and directed frames; a reference
// model decides each frame's outcome from the frame rules and pushes the
// expected output event into a queue; a monitor pops and compares whenever the
// DUT shows load or frame_err.
module tb_config_loader;

  localparam int NC = 10;
  localparam int W  = 1 + 8 + NC + 8 + 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rstn;
  logic          sen;
  logic          sdi;
  logic [7:0]    din;
  logic [NC-1:0] load;
  logic          busy;
  logic          frame_err;
  logic [7:0]    err_cnt;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  config_loader #(.NCELLS(NC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sen       (sen),
    .sdi       (sdi),
    .din       (din),
    .load      (load),
    .busy      (busy),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state: last accepted data and reject count.
  logic [7:0] m_din;
  int         m_errcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] pack_ev(input logic e, input logic [7:0] d,
                                           input logic [NC-1:0] l, input logic [7:0] ec,
                                           input logic [15:0] c);
    return {e, d, l, ec, c};
  endfunction

  // Monitor: every output event must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn && (frame_err || (|load))) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_event: err=%0b din=%0h load=%0h err_cnt=%0d expected none",
                 frame_err, din, load, err_cnt);
      end else begin
        check("event", 64'(pack_ev(frame_err, din, load, err_cnt, 16'(cyc))),
              64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge. Drives nbits bits with sen high, keeps
  // sen high for hold further cycles, then drops sen (sampled on the next edge).
  task automatic send_frame(input logic [3:0] a, input logic [7:0] d, input bit bad_par,
                            input int nbits, input int hold);
    logic [12:0]   bits;
    logic [NC-1:0] l;
    int            c0;
    bits = {a, d, (^{a, d}) ^ bad_par};
    c0   = cyc;
    // Model: a frame is good only if all 13 bits came, sen fell right after,
    // parity is even and the address names an existing cell.
    if (nbits == 13 && hold == 0 && !bad_par && int'(a) < NC) begin
      m_din = d;
      l = '0;
      l[a] = 1'b1;
      exp_q.push_back(pack_ev(1'b0, m_din, l, 8'(m_errcnt), 16'(c0 + 14)));
    end else begin
      m_errcnt = (m_errcnt >= 255) ? 255 : m_errcnt + 1;
      exp_q.push_back(pack_ev(1'b1, m_din, '0, 8'(m_errcnt),
                              16'((nbits == 13) ? c0 + 14 : c0 + nbits + 1)));
    end
    for (int i = 0; i < nbits; i++) begin
      sen = 1'b1;
      sdi = bits[12-i];
      @(negedge clk);
    end
    for (int j = 0; j < hold; j++) begin
      sen = 1'b1;
      sdi = 1'($urandom);
      @(negedge clk);
      check("busy_overrun", 64'(busy), 64'd1);
    end
    sen = 1'b0;
    sdi = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic gap(input int n);
    repeat (n + 1) @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [12:0] rb;
    rstn     = 1'b0;
    sen      = 1'b0;
    sdi      = 1'b0;
    m_din    = 8'h00;
    m_errcnt = 0;

    // Reset values, then release with sen low.
    repeat (3) @(negedge clk);
    check("rst_din", 64'(din), 64'h00);
    check("rst_load", 64'(load), 64'h0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    rstn = 1'b1;
    #1 check("busy_before_first_edge", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_after_first_edge", 64'(busy), 64'd0);
    check("din_after_release", 64'(din), 64'h00);
    gap(1);

    // Valid frame, then same frame with bad parity.
    send_frame(4'd3, 8'hA5, 1'b0, 13, 0);
    gap(2);
    wait_drain();
    check("din_hold_a5", 64'(din), 64'hA5);
    check("load_idle", 64'(load), 64'h0);
    send_frame(4'd3, 8'hA5, 1'b1, 13, 0);
    gap(2);
    wait_drain();
    check("din_kept_after_parity_err", 64'(din), 64'hA5);
    check("err_cnt_1", 64'(err_cnt), 64'd1);

    // Out-of-range address, then top legal address.
    send_frame(4'd12, 8'h5A, 1'b0, 13, 0);
    gap(1);
    send_frame(4'd9, 8'h3C, 1'b0, 13, 0);
    gap(1);
    wait_drain();
    check("din_3c", 64'(din), 64'h3C);
    check("err_cnt_2", 64'(err_cnt), 64'd2);

    // Short frame, overrun, back-to-back.
    send_frame(4'd1, 8'h42, 1'b0, 7, 0);
    gap(1);
    send_frame(4'd1, 8'h11, 1'b0, 13, 7);
    check("busy_until_sen_low", 64'(busy), 64'd1);
    @(negedge clk);
    check("idle_after_sen_low", 64'(busy), 64'd0);
    send_frame(4'd2, 8'hC3, 1'b0, 13, 0);
    gap(0);
    send_frame(4'd5, 8'h96, 1'b0, 13, 0);
    gap(1);
    wait_drain();
    check("din_b2b", 64'(din), 64'h96);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      automatic int nb = (($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 13);
      automatic int hd = ((nb == 13) && ($urandom_range(0, 7) == 0)) ? int'($urandom_range(1, 4)) : 0;
      send_frame(4'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 3) == 0), nb, hd);
      gap(int'($urandom_range(0, 3)));
    end
    wait_drain();
    check("din_after_random", 64'(din), 64'(m_din));

    // Saturation: 260 rejects of random kinds.
    for (int n = 0; n < 260; n++) begin
      case ($urandom_range(0, 2))
        0: send_frame(4'($urandom_range(0, 9)), 8'($urandom), 1'b0, int'($urandom_range(1, 12)), 0);
        1: send_frame(4'($urandom_range(0, 9)), 8'($urandom), 1'b1, 13, 0);
        default: send_frame(4'($urandom_range(10, 15)), 8'($urandom), 1'b0, 13, 0);
      endcase
      gap(0);
    end
    wait_drain();
    check("err_cnt_saturated", 64'(err_cnt), 64'd255);

    // Reset pulsed at E6 of a valid frame.
    rb = {4'd4, 8'h77, ^{4'd4, 8'h77}};
    for (int i = 0; i < 6; i++) begin
      sen = 1'b1;
      sdi = rb[12-i];
      @(negedge clk);
    end
    sdi = rb[6];
    @(posedge clk);
    #2 rstn = 1'b0;
    m_din    = 8'h00;
    m_errcnt = 0;
    #1;
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    check("midrst_din", 64'(din), 64'h00);
    check("midrst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 7; i < 13; i++) begin
      sdi = rb[12-i];
      @(negedge clk);
      check("wait_low_after_rst", 64'({busy, load}), 64'({1'b1, {NC{1'b0}}}));
    end
    sen = 1'b0;
    @(negedge clk);
    check("idle_after_rst_sen_low", 64'(busy), 64'd0);
    send_frame(4'd4, 8'h77, 1'b0, 13, 0);
    gap(2);
    wait_drain();
    check("din_after_rst_frame", 64'(din), 64'h77);
    check("err_cnt_after_rst_frame", 64'(err_cnt), 64'd0);

    gap(3);
    wait_drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/config_loader.md
# config_loader

Serial-to-parallel front end for the configuration register bank. It receives framed serial configuration words on `sdi`/`sen`, checks address and parity, and drives the shared 8-bit `din` bus plus a one-hot `load` strobe into the addressed 8-bit configuration cell. It sits directly upstream of the config cells and replaces per-cell parallel loading with a single 2-wire port. The block is triplicated by the TMR flow like the cells it feeds.

## Interface

Parameters:
- `NCELLS`, default 16: number of config cells driven; legal range 1..16. The address field is fixed at 4 bits.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `sen`, input, 1: frame enable. High for exactly the 13 bit cycles of a frame.
- `sdi`, input, 1: serial data, sampled on every edge where `sen`=1. MSB first.
- `din`, output, 8: data bus to all cells, registered.
- `load`, output, NCELLS: one-hot load strobe, registered.
- `busy`, output, 1: a frame is in progress or the block is waiting for `sen` low.
- `frame_err`, output, 1: one-cycle pulse when a frame is rejected.
- `err_cnt`, output, 8: count of rejected frames, saturating.

## Operation

- Frame format is 13 bits, in order: addr[3:0], data[7:0], parity.
- Parity is even. The XOR of all 13 bits must be 0.
- States: IDLE, SHIFT, EVAL, WAIT_LOW.
- Reset state is WAIT_LOW. After reset or any frame, a new frame starts only once `sen` has been sampled low at least one edge.
- IDLE → SHIFT on the edge that samples `sen`=1. That edge captures bit 0.
- SHIFT:
  - Captures one bit per edge into a 13-bit shift register. A 4-bit counter tracks the bit index.
  - `sen`=0 sampled before all 13 bits are captured is a short frame: go to IDLE and reject the frame.
- EVAL is entered after bit 12 is captured. At the EVAL edge, `sen` must be sampled 0.
- The frame is accepted if the parity is OK, addr < NCELLS, and `sen`=0. On acceptance:
  - `din` ← data.
  - `load[addr]` ← 1.
  - Next state is IDLE.
- Otherwise the frame is rejected:
  - No load is issued and `din` is unchanged.
  - Next state is WAIT_LOW if `sen`=1 (overrun), else IDLE.
- On any reject:
  - `frame_err` pulses for 1 cycle.
  - `err_cnt` increments and saturates at 255.
  - A reject with several causes counts once.
- `load` is high for exactly one cycle. At most one `load` bit is ever high.
- `din` holds its last accepted value indefinitely; cells sample it only when their `load` bit is set.
- `busy` = (state ≠ IDLE).

## Timing

- Reset values: `din`=0x00, `load`=0, `busy`=1 (WAIT_LOW), `frame_err`=0, `err_cnt`=0.
- Frame timing, with E0 as the first edge that samples `sen`=1:
  - Bits are captured at E0..E12.
  - EVAL happens at E13. `din`/`load`/`frame_err` change after E13.
  - The destination cell captures `din` at E14.
- Latency from the last bit to the cell register updating is 2 edges.
- Short-frame reject: `frame_err` is asserted after the first edge that samples `sen`=0 in SHIFT.
- Back-to-back frames: `sen` low at E13, high again at E14 is legal. E14 is then E0 of the next frame, giving a minimum frame period of 14 cycles.
- Reset asserted mid-frame: all outputs and the counter return to reset values immediately, the partial frame is discarded, and no `load` is issued.
- If `sen` is high when reset releases, the block stays in WAIT_LOW until `sen` is sampled low.

## Test plan

1. Reset release with `sen`=0 → `busy` 1 for one cycle, then 0. All other outputs stay at reset values.
2. Frame addr=3, data=0xA5, parity=0 → `load`=0x0008 and `din`=0xA5 for the single cycle after E13. `frame_err`=0 and `err_cnt`=0.
3. Same frame with parity=1 → no `load`, `frame_err` pulse after E13, `err_cnt`=1, `din` keeps its previous value.
4. NCELLS=10, frame addr=12 with valid parity → rejected, `err_cnt` increments. Then addr=9, data=0x3C → `load[9]`=1, `din`=0x3C.
5. Protocol errors:
   - `sen` dropped after 7 bits → rejected, `frame_err` after the `sen`-low edge, no `load`.
   - `sen` held for 20 cycles → overrun reject at E13; `busy` stays 1 until `sen` is sampled low.
   - Back-to-back valid frames 14 cycles apart → both loads issued.
6. Saturation and reset:
   - 260 rejected frames → `err_cnt`=255.
   - `rstn` pulsed low at E6 of a valid frame → `err_cnt`=0, no `load` for that frame.
   - The next frame after `sen` low loads normally.
